id_ex_reg: RTL and testbench

Pipeline register between the decode (ID) and execute (EX) stages of the 5-stage RV32I core. It captures the decoded instruction fields and operands from ID and presents the EX-stage `control_signal[10:2]` bundle consumed by the EX control decoder. It also detects load-use hazards (issuing a stall plus bubble), honours branch/jump flushes from EX, and keeps saturating stall and flush event counters.

---
 rtl/id_ex_reg.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register for the 5-stage RV32I core.
//
// It captures the decoded ID fields and operands and presents them to EX
// one cycle later. It detects load-use hazards and answers them with a
// stall plus a bubble. It honours branch/jump flushes from EX. It also keeps
// saturating stall and flush event counters.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_valid, id_instr       ID instruction and its valid flag
//   id_pc                    PC of the ID instruction
//   id_rs1_data, id_rs2_data register-file read data
//   id_imm                   sign-extended immediate
//   ex_flush                 EX resolved a taken branch/jump (ID is wrong-path)
//   ex_valid                 EX instruction is real
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm
//                            registered copies of the ID fields
//   ex_ctrl                  {instr[30], funct3, opcode[6:2]}
//   ex_rd, ex_rs1_addr, ex_rs2_addr
//                            register addresses of the EX instruction
//   ex_wb_en                 EX instruction writes a non-zero rd
//   id_stall                 combinational: hold PC and IF/ID this cycle
//   stall_cnt, flush_cnt     saturating event counters
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        ex_flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [8:0]  ex_ctrl,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic        ex_wb_en,
  output logic        id_stall,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // opcode[6:2] values that matter here
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // Bubble is addi x0,x0,0. An all-zero ctrl would decode as LB, so it is
  // never usable as a bubble.
  localparam logic [8:0] NOP_CTRL = 9'b0_000_00100;

  // Saturating increment shared by both event counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  logic [4:0] id_opcode_s;
  logic [4:0] id_rd_s;
  logic [4:0] id_rs1_s;
  logic [4:0] id_rs2_s;
  logic [8:0] id_ctrl_s;
  logic       rs1_used_s;
  logic       rs2_used_s;
  logic       id_wb_op_s;
  logic       ex_is_load_s;
  logic       rs1_match_s;
  logic       rs2_match_s;
  logic       hz_s;
  logic       bubble_s;
  logic       unused_instr_bits_s;

  assign id_opcode_s = id_instr[6:2];
  assign id_rd_s     = id_instr[11:7];
  assign id_rs1_s    = id_instr[19:15];
  assign id_rs2_s    = id_instr[24:20];
  assign id_ctrl_s   = {id_instr[30], id_instr[14:12], id_opcode_s};

  // Bits that carry nothing this stage needs (funct7 remainder, length code).
  assign unused_instr_bits_s = ^{id_instr[31], id_instr[29:25], id_instr[1:0]};

  // Which source registers the ID instruction actually reads.
  always_comb begin
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    case (id_opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
      end
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      default: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
      end
    endcase
  end

  // Whether the ID opcode writes a result back (stores/branches do not).
  always_comb begin
    id_wb_op_s = 1'b1;
    case (id_opcode_s)
      OP_STORE, OP_BRANCH: id_wb_op_s = 1'b0;
      default:             id_wb_op_s = 1'b1;
    endcase
  end

  // A load writing x0 can never cause a hazard; x0 is hardwired.
  assign ex_is_load_s = ex_valid & (ex_ctrl[4:0] == OP_LOAD) & (ex_rd != 5'd0);
  assign rs1_match_s  = rs1_used_s & (id_rs1_s == ex_rd);
  assign rs2_match_s  = rs2_used_s & (id_rs2_s == ex_rd);
  assign hz_s         = ex_is_load_s & id_valid & (rs1_match_s | rs2_match_s);

  // A flush discards the ID instruction anyway, so holding it would be pointless.
  assign id_stall = hz_s & ~ex_flush;

  // Reset, flush, hazard and an empty ID slot all collapse to the same bubble.
  assign bubble_s = ex_flush | hz_s | ~id_valid;

  // EX-stage register: load the bubble or capture the ID fields.
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_ctrl     <= NOP_CTRL;
      ex_rd       <= 5'd0;
      ex_rs1_addr <= 5'd0;
      ex_rs2_addr <= 5'd0;
      ex_wb_en    <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_ctrl     <= id_ctrl_s;
      ex_rd       <= id_rd_s;
      ex_rs1_addr <= id_rs1_s;
      ex_rs2_addr <= id_rs2_s;
      ex_wb_en    <= (id_rd_s != 5'd0) & id_wb_op_s;
    end
  end

  // Saturating stall/flush counters, counted on the edge ending the event cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (id_stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (ex_flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg. A driver applies one stimulus per cycle
// on the falling edge. A reference model predicts id_stall for that cycle and
// the EX state after the next rising edge, and pushes both predictions into
// queues. Two monitors pop the queues and compare against the DUT.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic        ex_flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rd, ex_rs1_addr, ex_rs2_addr;
  logic        ex_wb_en;
  logic        id_stall;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_wb_en(ex_wb_en), .id_stall(id_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [8:0]  ctrl;
    logic [4:0]  rd, rs1a, rs2a;
    logic        wb;
    logic [15:0] sc, fc;
  } ex_t;

  typedef struct packed {
    logic known;
    logic stall;
  } st_t;

  ex_t q_ex[$];
  st_t q_st[$];
  int  checks = 0;
  int  failures = 0;

  // reference model state
  ex_t  m;
  logic m_known = 1'b0;
  int   sc_m = 0;
  int   fc_m = 0;
  logic last_stall = 1'b0;

  localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW5   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] SW5   = 32'h0054A023; // sw  x5,0(x9)
  localparam logic [31:0] LUI5  = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] LW0   = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD00 = 32'h00000333; // add x6,x0,x0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive on the falling edge, then predict from the rules.
  task automatic step(input logic r, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] imm,
                      input logic fl);
    logic [4:0] op;
    logic use1, use2, hz, stall;
    st_t s;
    @(negedge clk);
    rst = r; id_valid = v; id_instr = instr; id_pc = pc;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; ex_flush = fl;
    op   = instr[6:2];
    use1 = !(op inside {5'b01101, 5'b00101, 5'b11011});
    use2 = op inside {5'b01100, 5'b01000, 5'b11000};
    hz   = m_known && m.valid && (m.ctrl[4:0] == 5'b00000) && (m.rd != 5'd0) && v &&
           ((use1 && instr[19:15] == m.rd) || (use2 && instr[24:20] == m.rd));
    stall = hz && !fl;
    s.known = m_known;
    s.stall = stall;
    q_st.push_back(s);
    last_stall = stall;
    if (r) begin
      sc_m = 0;
      fc_m = 0;
      m_known = 1'b1;
    end else begin
      if (fl) fc_m = (fc_m < 65535) ? fc_m + 1 : 65535;
      if (stall) sc_m = (sc_m < 65535) ? sc_m + 1 : 65535;
    end
    if (r || fl || hz || !v) begin
      m = '0;
      m.ctrl = 9'h004;
    end else begin
      m.valid = 1'b1;
      m.pc = pc; m.rs1d = d1; m.rs2d = d2; m.imm = imm;
      m.ctrl = {instr[30], instr[14:12], instr[6:2]};
      m.rd = instr[11:7]; m.rs1a = instr[19:15]; m.rs2a = instr[24:20];
      m.wb = (instr[11:7] != 5'd0) && !(op inside {5'b01000, 5'b11000});
    end
    m.sc = sc_m[15:0];
    m.fc = fc_m[15:0];
    if (m_known) q_ex.push_back(m);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops [10];
    logic [31:0] ins;
    ops = '{5'b00000, 5'b01000, 5'b11000, 5'b01100, 5'b01101,
            5'b00101, 5'b11011, 5'b00100, 5'b11001, 5'b11100};
    ins = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      ins[1:0]   = 2'b11;
      ins[6:2]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
    end
    return ins;
  endfunction

  // Monitor: EX-stage state after each rising edge.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_ex.size() > 0) begin
        e = q_ex.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rs1_data", ex_rs1_data, e.rs1d);
        chk("ex_rs2_data", ex_rs2_data, e.rs2d);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_rs1_addr", 32'(ex_rs1_addr), 32'(e.rs1a));
        chk("ex_rs2_addr", 32'(ex_rs2_addr), 32'(e.rs2a));
        chk("ex_wb_en", 32'(ex_wb_en), 32'(e.wb));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  // Monitor: combinational id_stall in the middle of each driven cycle.
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      #2;
      if (q_st.size() > 0) begin
        s = q_st.pop_front();
        if (s.known) chk("id_stall", 32'(id_stall), 32'(s.stall));
      end
    end
  end

  initial begin
    logic        r, v, fl;
    logic [31:0] ins, pc, d1, d2, imm;
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; id_pc = 32'd0;
    id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; ex_flush = 1'b0;
    m = '0;

    // reset with random inputs
    repeat (2) step(1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
    #6;
    chk("rst_ctrl", 32'(ex_ctrl), 32'h004);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_wb", 32'(ex_wb_en), 32'd0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    chk("rst_stall", 32'(id_stall), 32'd0);

    // pass-through
    step(1'b0, 1'b1, ADD3, 32'h100, 32'h11, 32'h22, 32'h0, 1'b0);
    #6;
    chk("pt_ctrl", 32'(ex_ctrl), 32'h00C);
    chk("pt_rd", 32'(ex_rd), 32'd3);
    chk("pt_wb", 32'(ex_wb_en), 32'd1);
    chk("pt_pc", ex_pc, 32'h100);
    chk("pt_valid", 32'(ex_valid), 32'd1);

    // load-use on rs1, held instruction advances after one bubble
    step(1'b0, 1'b1, LW5, 32'h104, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, ADD6, 32'h108, 32'h1, 32'h2, 32'h0, 1'b0);
    #1; chk("lu_stall", 32'(id_stall), 32'd1);
    #5; chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    step(1'b0, 1'b1, ADD6, 32'h108, 32'h1, 32'h2, 32'h0, 1'b0);
    #1; chk("lu_release", 32'(id_stall), 32'd0);
    #5; chk("lu_adv_rd", 32'(ex_rd), 32'd6);

    // rs2-only use
    step(1'b0, 1'b1, LW5, 32'h10C, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, SW5, 32'h110, 32'h0, 32'h0, 32'h0, 1'b0);
    #1; chk("sw_stall", 32'(id_stall), 32'd1);
    step(1'b0, 1'b1, SW5, 32'h110, 32'h0, 32'h0, 32'h0, 1'b0);

    // LUI does not read rs1
    step(1'b0, 1'b1, LW5, 32'h114, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, LUI5, 32'h118, 32'h0, 32'h0, 32'h28000, 1'b0);
    #1; chk("lui_stall", 32'(id_stall), 32'd0);

    // load into x0 never stalls
    step(1'b0, 1'b1, LW0, 32'h11C, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, ADD00, 32'h120, 32'h0, 32'h0, 32'h0, 1'b0);
    #1; chk("x0_stall", 32'(id_stall), 32'd0);
    #5; chk("x0_valid", 32'(ex_valid), 32'd1);

    // flush beats hazard
    step(1'b0, 1'b1, LW5, 32'h124, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, ADD6, 32'h128, 32'h0, 32'h0, 32'h0, 1'b1);
    #1; chk("fh_stall", 32'(id_stall), 32'd0);
    #5; chk("fh_bubble", 32'(ex_valid), 32'd0);
    chk("fh_fcnt", 32'(flush_cnt), 32'd1);
    chk("fh_scnt", 32'(stall_cnt), 32'd2);

    // randomized traffic; a stalled instruction is held like a real front end
    ins = 32'd0; pc = 32'd0; d1 = 32'd0; d2 = 32'd0; imm = 32'd0; v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 99) < 10);
      if (!last_stall) begin
        v = ($urandom_range(0, 99) < 85);
        ins = rand_instr(); pc = $urandom; d1 = $urandom; d2 = $urandom; imm = $urandom;
      end
      step(r, v, ins, pc, d1, d2, imm, fl);
    end

    // flush counter saturation, then a mid-run reset
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 1'($urandom), rand_instr(), $urandom, $urandom, $urandom, $urandom, 1'b1);
    end
    #6; chk("sat_fcnt", 32'(flush_cnt), 32'h0000FFFF);
    step(1'b1, 1'b1, ADD3, 32'h200, 32'h0, 32'h0, 32'h0, 1'b1);
    #6;
    chk("mid_rst_fcnt", 32'(flush_cnt), 32'd0);
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_ctrl", 32'(ex_ctrl), 32'h004);

    // drain with a bounded wait
    for (int i = 0; i < 4 && (q_ex.size() != 0 || q_st.size() != 0); i++) @(posedge clk);
    #3;
    chk("drain_ex", 32'(q_ex.size()), 32'd0);
    chk("drain_st", 32'(q_st.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
